// File: rtl/elevator_plant.sv
// Car-and-shaft model closing the loop around the four-floor elevator core.
// Registered sensors and status; position tracked as floor index plus sub-floor step count.
module elevator_plant #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int START_FLOOR   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       stop,
  input  logic       open_door,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       S4,
  output logic [1:0] position,
  output logic       moving,
  output logic       door_is_open,
  output logic       fault
);
  typedef enum logic [1:0] {AT_FLOOR, MOVING, DOOR_OPEN} state_t;

  localparam logic [7:0] SUB_MAX   = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD = 8'(DOOR_CYCLES);
  localparam logic [1:0] FLOOR0    = 2'(START_FLOOR);

  state_t     state, state_nxt;
  logic [1:0] floor, floor_nxt;
  logic [7:0] sub, sub_nxt;
  logic [7:0] timer, timer_nxt;
  logic       fault_nxt;
  logic       go_up, go_down, aligned, moved;

  always_comb begin
    go_up     = up & ~down & ~stop;
    go_down   = down & ~up & ~stop;
    aligned   = (sub == 8'd0);
    state_nxt = state;
    floor_nxt = floor;
    sub_nxt   = sub;
    timer_nxt = timer;
    fault_nxt = fault | (up & down);
    case (state)
      DOOR_OPEN: begin
        if (up | down)
          fault_nxt = 1'b1;
        if (timer != 8'd0)
          timer_nxt = timer - 8'd1;
        // Timer reaching zero on this edge already counts as expired.
        if (timer_nxt == 8'd0 && !open_door)
          state_nxt = AT_FLOOR;
      end
      default: begin
        if (go_up) begin
          if (aligned && floor == 2'd3) begin
            fault_nxt = 1'b1;
          end else if (sub == SUB_MAX) begin
            sub_nxt   = 8'd0;
            floor_nxt = floor + 2'd1;
          end else begin
            sub_nxt = sub + 8'd1;
          end
        end else if (go_down) begin
          if (aligned && floor == 2'd0) begin
            fault_nxt = 1'b1;
          end else if (aligned) begin
            floor_nxt = floor - 2'd1;
            sub_nxt   = SUB_MAX;
          end else begin
            sub_nxt = sub - 8'd1;
          end
        end else if (open_door && aligned) begin
          state_nxt = DOOR_OPEN;
          timer_nxt = DOOR_LOAD;
        end
        if (open_door && !aligned)
          fault_nxt = 1'b1;
        if (state_nxt != DOOR_OPEN)
          state_nxt = (sub_nxt == 8'd0) ? AT_FLOOR : MOVING;
      end
    endcase
  end

  assign moved = (floor_nxt != floor) || (sub_nxt != sub);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= AT_FLOOR;
      floor        <= FLOOR0;
      sub          <= 8'd0;
      timer        <= 8'd0;
      S1           <= (FLOOR0 == 2'd0);
      S2           <= (FLOOR0 == 2'd1);
      S3           <= (FLOOR0 == 2'd2);
      S4           <= (FLOOR0 == 2'd3);
      position     <= FLOOR0;
      moving       <= 1'b0;
      door_is_open <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_nxt;
      floor        <= floor_nxt;
      sub          <= sub_nxt;
      timer        <= timer_nxt;
      S1           <= (sub_nxt == 8'd0) && (floor_nxt == 2'd0);
      S2           <= (sub_nxt == 8'd0) && (floor_nxt == 2'd1);
      S3           <= (sub_nxt == 8'd0) && (floor_nxt == 2'd2);
      S4           <= (sub_nxt == 8'd0) && (floor_nxt == 2'd3);
      position     <= floor_nxt;
      moving       <= moved;
      door_is_open <= (state_nxt == DOOR_OPEN);
      fault        <= fault_nxt;
    end
  end
endmodule
